// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register of configurable depth with valid, stall, flush,
// write-back data select and an optional guard against writes to register 0.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int RD_W       = 5,
    parameter int DEPTH      = 1,
    parameter int ZERO_GUARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic              mem_to_reg_out
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("mem_wb_pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    localparam int LAST = DEPTH - 1;

    logic              vld_q [DEPTH];
    logic [RD_W-1:0]   rd_q  [DEPTH];
    logic              m2r_q [DEPTH];
    logic              rw_q  [DEPTH];
    logic [DATA_W-1:0] alu_q [DEPTH];
    logic [DATA_W-1:0] rdd_q [DEPTH];

    function automatic logic [DATA_W-1:0] wb_select(
        input logic              sel,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] alu_val
    );
        return sel ? mem_val : alu_val;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                rd_q[i]  <= '0;
                m2r_q[i] <= 1'b0;
                rw_q[i]  <= 1'b0;
                alu_q[i] <= '0;
                rdd_q[i] <= '0;
            end
        end else if (flush) begin
            // Only the write-relevant control bits are squashed; data is left as is.
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                m2r_q[i] <= 1'b0;
                rw_q[i]  <= 1'b0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            rd_q[0]  <= rd_in;
            m2r_q[0] <= mem_to_reg;
            rw_q[0]  <= reg_write & in_valid;
            alu_q[0] <= alu_result;
            rdd_q[0] <= read_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                rd_q[i]  <= rd_q[i-1];
                m2r_q[i] <= m2r_q[i-1];
                rw_q[i]  <= rw_q[i-1];
                alu_q[i] <= alu_q[i-1];
                rdd_q[i] <= rdd_q[i-1];
            end
        end
    end

    logic rd_nonzero;
    assign rd_nonzero = (rd_q[LAST] != '0) || (ZERO_GUARD == 0);

    assign wb_valid       = vld_q[LAST];
    assign wb_rd          = rd_q[LAST];
    assign wb_data        = wb_select(m2r_q[LAST], rdd_q[LAST], alu_q[LAST]);
    assign wb_reg_write   = vld_q[LAST] & rw_q[LAST] & rd_nonzero;
    assign alu_res_out    = alu_q[LAST];
    assign read_data_out  = rdd_q[LAST];
    assign mem_to_reg_out = m2r_q[LAST];

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: four instances (depth 1/2/3, guard on/off)
// share one input stream; each scenario task checks the relevant instance.
module tb_mem_wb_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, stall, flush, mem_to_reg, reg_write;
    logic [RW-1:0] rd_in;
    logic [DW-1:0] alu_result, read_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // instance a: DEPTH=1, guard on
    logic a_vld, a_rw, a_m2r; logic [RW-1:0] a_rd; logic [DW-1:0] a_data, a_alu, a_rdd;
    // instance b: DEPTH=2
    logic b_vld, b_rw, b_m2r; logic [RW-1:0] b_rd; logic [DW-1:0] b_data, b_alu, b_rdd;
    // instance c: DEPTH=3
    logic c_vld, c_rw, c_m2r; logic [RW-1:0] c_rd; logic [DW-1:0] c_data, c_alu, c_rdd;
    // instance z: DEPTH=1, guard off
    logic z_vld, z_rw, z_m2r; logic [RW-1:0] z_rd; logic [DW-1:0] z_data, z_alu, z_rdd;

    mem_wb_pipe_reg #(.DATA_W(DW), .RD_W(RW), .DEPTH(1), .ZERO_GUARD(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_in(rd_in), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_result(alu_result), .read_data(read_data),
        .wb_valid(a_vld), .wb_reg_write(a_rw), .wb_rd(a_rd), .wb_data(a_data),
        .alu_res_out(a_alu), .read_data_out(a_rdd), .mem_to_reg_out(a_m2r));

    mem_wb_pipe_reg #(.DATA_W(DW), .RD_W(RW), .DEPTH(2), .ZERO_GUARD(1)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_in(rd_in), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_result(alu_result), .read_data(read_data),
        .wb_valid(b_vld), .wb_reg_write(b_rw), .wb_rd(b_rd), .wb_data(b_data),
        .alu_res_out(b_alu), .read_data_out(b_rdd), .mem_to_reg_out(b_m2r));

    mem_wb_pipe_reg #(.DATA_W(DW), .RD_W(RW), .DEPTH(3), .ZERO_GUARD(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_in(rd_in), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_result(alu_result), .read_data(read_data),
        .wb_valid(c_vld), .wb_reg_write(c_rw), .wb_rd(c_rd), .wb_data(c_data),
        .alu_res_out(c_alu), .read_data_out(c_rdd), .mem_to_reg_out(c_m2r));

    mem_wb_pipe_reg #(.DATA_W(DW), .RD_W(RW), .DEPTH(1), .ZERO_GUARD(0)) u_z (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_in(rd_in), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_result(alu_result), .read_data(read_data),
        .wb_valid(z_vld), .wb_reg_write(z_rw), .wb_rd(z_rd), .wb_data(z_data),
        .alu_res_out(z_alu), .read_data_out(z_rdd), .mem_to_reg_out(z_m2r));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] r, input logic m2r,
                         input logic rw, input logic [DW-1:0] alu, input logic [DW-1:0] mem);
        in_valid = v; rd_in = r; mem_to_reg = m2r; reg_write = rw;
        alu_result = alu; read_data = mem;
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b1; flush = 1'b1; reset = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 1'b1, 32'h0000_0033, 32'h0000_A5A5);
        step();
        total++; if (a_vld !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", a_vld); end
        total++; if (a_rw !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b want=0", a_rw); end
        total++; if (a_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", a_data); end
        total++; if (a_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", a_rd); end
        total++; if (c_vld !== 1'b0 || c_rd !== 5'd0 || c_alu !== 32'h0)
            begin bad++; $display("FAIL reset_depth3 got vld=%b rd=%0d alu=%h want 0", c_vld, c_rd, c_alu); end
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        step();
        total++; if (a_vld !== 1'b1 || a_rd !== 5'd7 || a_data !== 32'h0000_A5A5)
            begin bad++; $display("FAIL reset_first got vld=%b rd=%0d data=%h want 1/7/0000a5a5", a_vld, a_rd, a_data); end
    endtask

    task automatic test_select();
        do_reset();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF);
        step();
        total++; if (a_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sel_mem got=%h want=deadbeef", a_data); end
        total++; if (a_rd !== 5'd5 || a_rw !== 1'b1) begin bad++; $display("FAIL sel_mem_ctl got rd=%0d rw=%b want 5/1", a_rd, a_rw); end
        total++; if (a_alu !== 32'h12 || a_rdd !== 32'hDEAD_BEEF || a_m2r !== 1'b1)
            begin bad++; $display("FAIL sel_raw got alu=%h rdd=%h m2r=%b want 12/deadbeef/1", a_alu, a_rdd, a_m2r); end
        mem_to_reg = 1'b0;
        step();
        total++; if (a_data !== 32'h0000_0012) begin bad++; $display("FAIL sel_alu got=%h want=12", a_data); end
        total++; if (a_m2r !== 1'b0) begin bad++; $display("FAIL sel_alu_m2r got=%b want=0", a_m2r); end
    endtask

    task automatic test_depth_stall();
        logic [RW-1:0] in_rd  [9];
        logic          st     [9];
        logic [RW-1:0] exp_rd [9];
        in_rd  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5, 5'd6, 5'd7};
        st     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_rd = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, in_rd[k], 1'b0, 1'b1, {27'd0, in_rd[k]}, 32'h0);
            stall = st[k];
            step();
            total++;
            if (c_rd !== exp_rd[k] || c_vld !== (k >= 2))
                begin bad++; $display("FAIL depth3_edge%0d got rd=%0d vld=%b want rd=%0d vld=%b",
                                      k + 1, c_rd, c_vld, exp_rd[k], (k >= 2)); end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd8, 1'b1, 1'b1, 32'h1, 32'h8);
        step();
        drive(1'b1, 5'd9, 1'b1, 1'b1, 32'h2, 32'h9);
        step();
        total++; if (b_vld !== 1'b1 || b_rd !== 5'd8 || b_rw !== 1'b1)
            begin bad++; $display("FAIL flush_pre got vld=%b rd=%0d rw=%b want 1/8/1", b_vld, b_rd, b_rw); end
        drive(1'b1, 5'd10, 1'b1, 1'b1, 32'h3, 32'hA);
        flush = 1'b1; stall = 1'b1;
        step();
        total++; if (b_vld !== 1'b0 || b_rw !== 1'b0)
            begin bad++; $display("FAIL flush_c1 got vld=%b rw=%b want 0/0", b_vld, b_rw); end
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 5'd11, 1'b0, 1'b0, 32'h4, 32'hB);
        step();
        total++; if (b_vld !== 1'b0 || b_rw !== 1'b0)
            begin bad++; $display("FAIL flush_c2 got vld=%b rw=%b want 0/0", b_vld, b_rw); end
    endtask

    task automatic test_zero_guard();
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 1'b1, 32'h55, 32'h77);
        step();
        total++; if (a_rw !== 1'b0) begin bad++; $display("FAIL zg_on_rw got=%b want=0", a_rw); end
        total++; if (a_data !== 32'h55 || a_vld !== 1'b1)
            begin bad++; $display("FAIL zg_on_data got data=%h vld=%b want 55/1", a_data, a_vld); end
        total++; if (z_rw !== 1'b1) begin bad++; $display("FAIL zg_off_rw got=%b want=1", z_rw); end
    endtask

    task automatic test_bubble_reset_stall();
        do_reset();
        drive(1'b0, 5'd3, 1'b1, 1'b1, 32'h66, 32'h99);
        step();
        total++; if (a_vld !== 1'b0 || a_rw !== 1'b0)
            begin bad++; $display("FAIL bubble_d1 got vld=%b rw=%b want 0/0", a_vld, a_rw); end
        total++; if (z_rw !== 1'b0) begin bad++; $display("FAIL bubble_noguard got=%b want=0", z_rw); end
        step();
        step();
        total++; if (c_vld !== 1'b0 || c_rw !== 1'b0 || c_rd !== 5'd3)
            begin bad++; $display("FAIL bubble_d3 got vld=%b rw=%b rd=%0d want 0/0/3", c_vld, c_rw, c_rd); end
        drive(1'b1, 5'd6, 1'b0, 1'b1, 32'h6, 32'h0);
        step(); step(); step();
        total++; if (c_vld !== 1'b1 || c_rw !== 1'b1 || c_rd !== 5'd6)
            begin bad++; $display("FAIL prestall_d3 got vld=%b rw=%b rd=%0d want 1/1/6", c_vld, c_rw, c_rd); end
        stall = 1'b1; reset = 1'b0;
        step();
        total++; if (c_vld !== 1'b0 || c_rd !== 5'd0 || c_data !== 32'h0 || c_rw !== 1'b0)
            begin bad++; $display("FAIL rst_stall_d3 got vld=%b rd=%0d data=%h rw=%b want 0", c_vld, c_rd, c_data, c_rw); end
        total++; if (b_vld !== 1'b0 || b_alu !== 32'h0)
            begin bad++; $display("FAIL rst_stall_d2 got vld=%b alu=%h want 0/0", b_vld, b_alu); end
        reset = 1'b1; stall = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        test_reset();
        test_select();
        test_depth_stall();
        test_flush();
        test_zero_guard();
        test_bubble_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
